// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory arbiter (FSM encoding, parameter defaults).
package dmem_arbiter_pkg;

  localparam int DEF_ADDR_W       = 14;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_STARVE_LIMIT = 8;

  typedef enum logic {
    ARB   = 1'b0,
    HLOCK = 1'b1
  } arb_state_e;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/arb_starve_cnt.sv
// Counts consecutive cycles a pending host request was denied; saturates at LIMIT.
module arb_starve_cnt #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic host_req,
  input  logic host_gnt,
  output logic starved
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!host_req || host_gnt) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(LIMIT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign starved = (cnt_q == CNT_W'(LIMIT));

endmodule

// File: rtl/dmem_arbiter.sv
// CPU/host arbiter in front of a single-port synchronous data memory.
// Optional DMEM_ARB_STATS_EN adds saturating grant/starvation counters.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_lock,
  output logic              host_gnt,
  output logic              host_rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [31:0]       cpu_beats,
  output logic [31:0]       host_beats,
  output logic [31:0]       starve_events
`endif
);

  arb_state_e state_q, state_d;
  logic       cpu_rd_q, cpu_rd_d;
  logic       host_rd_q, host_rd_d;
  logic       starved;

  // Grants are masked while rst is low so nothing reaches memory during reset.
  always_comb begin
    state_d  = state_q;
    cpu_gnt  = 1'b0;
    host_gnt = 1'b0;
    if (rst) begin
      unique case (state_q)
        ARB: begin
          if (cpu_req && !starved) begin
            cpu_gnt = 1'b1;
          end else if (host_req) begin
            host_gnt = 1'b1;
            if (host_lock) state_d = HLOCK;
          end
        end
        HLOCK: begin
          host_gnt = host_req;
          if (!host_req || !host_lock) state_d = ARB;
        end
        default: state_d = ARB;
      endcase
    end
  end

  assign cpu_rd_d  = cpu_gnt & ~cpu_we;
  assign host_rd_d = host_gnt & ~host_we;

  always_ff @(posedge CLOCK_50) begin
    if (!rst) begin
      state_q   <= ARB;
      cpu_rd_q  <= 1'b0;
      host_rd_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cpu_rd_q  <= cpu_rd_d;
      host_rd_q <= host_rd_d;
    end
  end

  arb_starve_cnt #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk     (CLOCK_50),
    .rst     (rst),
    .host_req(host_req),
    .host_gnt(host_gnt),
    .starved (starved)
  );

  assign mem_en    = cpu_gnt | host_gnt;
  assign mem_we    = host_gnt ? host_we : (cpu_gnt & cpu_we);
  assign mem_addr  = host_gnt ? host_addr : cpu_addr;
  assign mem_wdata = host_gnt ? host_wdata : cpu_wdata;
  assign rdata     = mem_rdata;

  // A read captured on the edge just before reset asserts must not surface.
  assign cpu_rvalid  = cpu_rd_q & rst;
  assign host_rvalid = host_rd_q & rst;

`ifdef DMEM_ARB_STATS_EN
  logic [31:0] cpu_beats_q, cpu_beats_d;
  logic [31:0] host_beats_q, host_beats_d;
  logic [31:0] starve_events_q, starve_events_d;
  logic        forced_host;

  // In ARB a host grant while the CPU is asking can only come from starvation.
  assign forced_host = host_gnt & cpu_req & (state_q == ARB);

  always_comb begin
    cpu_beats_d     = cpu_gnt     ? sat_inc32(cpu_beats_q)     : cpu_beats_q;
    host_beats_d    = host_gnt    ? sat_inc32(host_beats_q)    : host_beats_q;
    starve_events_d = forced_host ? sat_inc32(starve_events_q) : starve_events_q;
  end

  always_ff @(posedge CLOCK_50) begin
    if (!rst) begin
      cpu_beats_q     <= '0;
      host_beats_q    <= '0;
      starve_events_q <= '0;
    end else begin
      cpu_beats_q     <= cpu_beats_d;
      host_beats_q    <= host_beats_d;
      starve_events_q <= starve_events_d;
    end
  end

  assign cpu_beats     = cpu_beats_q;
  assign host_beats    = host_beats_q;
  assign starve_events = starve_events_q;
`endif

endmodule
